// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, forwarding sources and ALU-facing results.
// The slave side is the stage itself; the master side is whatever surrounds it.
interface id_ex_stage_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          stall;
    logic          flush;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm32;
    logic [4:0]    id_shamt;
    logic [AW-1:0] id_rs_addr;
    logic [AW-1:0] id_rt_addr;
    logic [AW-1:0] id_rd_addr;
    logic [4:0]    id_alu_conf;
    logic          id_sign;
    logic          id_src1_shamt;
    logic          id_src2_imm;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_trap_ovf;
    logic          exmem_reg_write;
    logic [AW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;
    logic          memwb_reg_write;
    logic [AW-1:0] memwb_rd;
    logic [DW-1:0] memwb_result;
    logic          alu_overflow;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_in2;
    logic [4:0]    alu_conf;
    logic          alu_sign;
    logic [DW-1:0] ex_store_data;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          load_use_stall;

    modport master (
        output stall, flush, id_rs_data, id_rt_data, id_imm32, id_shamt,
               id_rs_addr, id_rt_addr, id_rd_addr, id_alu_conf, id_sign,
               id_src1_shamt, id_src2_imm, id_reg_write, id_mem_read,
               id_mem_write, id_trap_ovf, exmem_reg_write, exmem_rd,
               exmem_result, memwb_reg_write, memwb_rd, memwb_result, alu_overflow,
        input  alu_in1, alu_in2, alu_conf, alu_sign, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
    );

    modport slave (
        input  stall, flush, id_rs_data, id_rt_data, id_imm32, id_shamt,
               id_rs_addr, id_rt_addr, id_rd_addr, id_alu_conf, id_sign,
               id_src1_shamt, id_src2_imm, id_reg_write, id_mem_read,
               id_mem_write, id_trap_ovf, exmem_reg_write, exmem_rd,
               exmem_result, memwb_reg_write, memwb_rd, memwb_result, alu_overflow,
        output alu_in1, alu_in2, alu_conf, alu_sign, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, EX/MEM and MEM/WB forwarding,
// ALU operand selection and overflow-trap write suppression.
module id_ex_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm32;
        logic [4:0]    shamt;
        logic [AW-1:0] rs_addr;
        logic [AW-1:0] rt_addr;
        logic [AW-1:0] rd_addr;
        logic [4:0]    alu_conf;
        logic          sign;
        logic          src1_shamt;
        logic          src2_imm;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          trap_ovf;
    } ex_fields_t;

    ex_fields_t    ex_q;
    ex_fields_t    id_in;
    logic          hazard;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    always_comb begin
        id_in            = '0;
        id_in.rs_data    = bus.id_rs_data;
        id_in.rt_data    = bus.id_rt_data;
        id_in.imm32      = bus.id_imm32;
        id_in.shamt      = bus.id_shamt;
        id_in.rs_addr    = bus.id_rs_addr;
        id_in.rt_addr    = bus.id_rt_addr;
        id_in.rd_addr    = bus.id_rd_addr;
        id_in.alu_conf   = bus.id_alu_conf;
        id_in.sign       = bus.id_sign;
        id_in.src1_shamt = bus.id_src1_shamt;
        id_in.src2_imm   = bus.id_src2_imm;
        id_in.reg_write  = bus.id_reg_write;
        id_in.mem_read   = bus.id_mem_read;
        id_in.mem_write  = bus.id_mem_write;
        id_in.trap_ovf   = bus.id_trap_ovf;
    end

    // A load in EX whose destination feeds the instruction in ID must wait one cycle.
    assign hazard = ex_q.mem_read && (ex_q.rd_addr != '0) &&
                    ((ex_q.rd_addr == bus.id_rs_addr) || (ex_q.rd_addr == bus.id_rt_addr));

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else if (bus.flush || hazard) begin
            ex_q <= '0;
        end else if (!bus.stall) begin
            ex_q <= id_in;
        end
    end

    // The newer EX/MEM result shadows MEM/WB; register 0 is never forwarded.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_q.rs_addr)) begin
            fwd_rs = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) &&
                     (bus.memwb_rd == ex_q.rs_addr)) begin
            fwd_rs = bus.memwb_result;
        end
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_q.rt_addr)) begin
            fwd_rt = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) &&
                     (bus.memwb_rd == ex_q.rt_addr)) begin
            fwd_rt = bus.memwb_result;
        end
    end

    assign bus.alu_in1        = ex_q.src1_shamt ? {{(DW - 5){1'b0}}, ex_q.shamt} : fwd_rs;
    assign bus.alu_in2        = ex_q.src2_imm ? ex_q.imm32 : fwd_rt;
    assign bus.alu_conf       = ex_q.alu_conf;
    assign bus.alu_sign       = ex_q.sign;
    assign bus.ex_store_data  = fwd_rt;
    assign bus.ex_rd          = ex_q.rd_addr;
    assign bus.ex_reg_write   = ex_q.reg_write && !(ex_q.trap_ovf && bus.alu_overflow);
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.ex_mem_write   = ex_q.mem_write;
    assign bus.load_use_stall = hazard;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal checks plus randomized traffic compared every
// cycle against a behavioural model of the instruction sitting in EX.
module tb_id_ex_stage;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(DW), .AW(AW)) bus ();
    id_ex_stage #(.DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Model: the decoded instruction currently occupying EX (all-zero means bubble).
    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  conf;
        logic        sign;
        logic        use_shamt;
        logic        use_imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        trap;
    } instr_t;

    instr_t ex_m;
    int     passed = 0;
    int     total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
    endtask

    function automatic instr_t id_instr();
        instr_t i;
        i.rs_data   = bus.id_rs_data;
        i.rt_data   = bus.id_rt_data;
        i.imm       = bus.id_imm32;
        i.shamt     = bus.id_shamt;
        i.rs        = bus.id_rs_addr;
        i.rt        = bus.id_rt_addr;
        i.rd        = bus.id_rd_addr;
        i.conf      = bus.id_alu_conf;
        i.sign      = bus.id_sign;
        i.use_shamt = bus.id_src1_shamt;
        i.use_imm   = bus.id_src2_imm;
        i.rw        = bus.id_reg_write;
        i.mr        = bus.id_mem_read;
        i.mw        = bus.id_mem_write;
        i.trap      = bus.id_trap_ovf;
        return i;
    endfunction

    // Load in EX producing a register the ID instruction reads.
    function automatic logic model_lus();
        return ex_m.mr && ex_m.rd != 0 && (ex_m.rd == bus.id_rs_addr || ex_m.rd == bus.id_rt_addr);
    endfunction

    // Architectural value of a register as seen in EX: newest in-flight producer wins.
    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return rf;
        if (bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
        return rf;
    endfunction

    always @(posedge clk) begin
        logic lus;
        lus = model_lus();
        if (reset || bus.flush || lus) ex_m = '0;
        else if (!bus.stall) ex_m = id_instr();
    end

    always @(negedge clk) begin
        logic [31:0] rs_v;
        logic [31:0] rt_v;
        rs_v = reg_value(ex_m.rs, ex_m.rs_data);
        rt_v = reg_value(ex_m.rt, ex_m.rt_data);
        check("alu_in1", bus.alu_in1, ex_m.use_shamt ? {27'b0, ex_m.shamt} : rs_v);
        check("alu_in2", bus.alu_in2, ex_m.use_imm ? ex_m.imm : rt_v);
        check("alu_conf", 32'(bus.alu_conf), 32'(ex_m.conf));
        check("alu_sign", 32'(bus.alu_sign), 32'(ex_m.sign));
        check("ex_store_data", bus.ex_store_data, rt_v);
        check("ex_rd", 32'(bus.ex_rd), 32'(ex_m.rd));
        check("ex_reg_write", 32'(bus.ex_reg_write), 32'(ex_m.rw && !(ex_m.trap && bus.alu_overflow)));
        check("ex_mem_read", 32'(bus.ex_mem_read), 32'(ex_m.mr));
        check("ex_mem_write", 32'(bus.ex_mem_write), 32'(ex_m.mw));
        check("load_use_stall", 32'(bus.load_use_stall), 32'(model_lus()));
    end

    task automatic clear_id();
        bus.stall = 0; bus.flush = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm32 = 0; bus.id_shamt = 0;
        bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0; bus.id_alu_conf = 0;
        bus.id_sign = 0; bus.id_src1_shamt = 0; bus.id_src2_imm = 0; bus.id_reg_write = 0;
        bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_trap_ovf = 0;
    endtask

    task automatic fwd_off();
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
    endtask

    task automatic randomize_id();
        bus.id_rs_data    = $urandom; bus.id_rt_data = $urandom; bus.id_imm32 = $urandom;
        bus.id_shamt      = 5'($urandom); bus.id_alu_conf = 5'($urandom);
        bus.id_rs_addr    = 5'($urandom_range(0, 3));
        bus.id_rt_addr    = 5'($urandom_range(0, 3));
        bus.id_rd_addr    = 5'($urandom_range(0, 3));
        bus.id_sign       = 1'($urandom); bus.id_src1_shamt = 1'($urandom);
        bus.id_src2_imm   = 1'($urandom); bus.id_reg_write = 1'($urandom);
        bus.id_mem_read   = ($urandom_range(0, 9) < 3); bus.id_mem_write = 1'($urandom);
        bus.id_trap_ovf   = 1'($urandom);
    endtask

    initial begin
        reset = 1; clear_id(); fwd_off(); bus.alu_overflow = 0;
        @(negedge clk);
        check("rst alu_conf", 32'(bus.alu_conf), 0);
        check("rst ex_reg_write", 32'(bus.ex_reg_write), 0);
        check("rst ex_rd", 32'(bus.ex_rd), 0);
        check("rst load_use_stall", 32'(bus.load_use_stall), 0);
        check("rst alu_in1", bus.alu_in1, 0);
        check("rst alu_in2", bus.alu_in2, 0);

        // add $3,$1,$2 with both forwarding paths targeting $1
        #1 reset = 0;
        bus.id_rs_addr = 1; bus.id_rt_addr = 2; bus.id_rd_addr = 3;
        bus.id_rs_data = 5; bus.id_rt_data = 7; bus.id_reg_write = 1;
        bus.exmem_reg_write = 1; bus.exmem_rd = 1; bus.exmem_result = 100;
        bus.memwb_reg_write = 1; bus.memwb_rd = 1; bus.memwb_result = 50;
        @(negedge clk);
        check("fwd exmem alu_in1", bus.alu_in1, 100);
        check("fwd alu_in2", bus.alu_in2, 7);
        check("add ex_rd", 32'(bus.ex_rd), 3);
        #1 bus.exmem_rd = 0; bus.memwb_rd = 0;
        #1 check("nofwd alu_in1", bus.alu_in1, 5);
        check("nofwd alu_in2", bus.alu_in2, 7);

        // sll $4,$2,3
        clear_id(); fwd_off();
        bus.id_rt_addr = 2; bus.id_rd_addr = 4; bus.id_shamt = 3; bus.id_src1_shamt = 1;
        bus.id_rt_data = 32'h10; bus.id_alu_conf = 5'b11001; bus.id_reg_write = 1;
        @(negedge clk);
        check("sll alu_in1", bus.alu_in1, 3);
        check("sll alu_in2", bus.alu_in2, 32'h10);
        check("sll alu_conf", 32'(bus.alu_conf), 32'h19);

        // lw $5 then a consumer of $5
        #1 clear_id();
        bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_rd_addr = 5;
        bus.id_src2_imm = 1; bus.id_imm32 = 8;
        @(negedge clk);
        #1 clear_id();
        bus.id_rs_addr = 5; bus.id_rt_addr = 6; bus.id_rd_addr = 7; bus.id_reg_write = 1;
        #1 check("hazard lus", 32'(bus.load_use_stall), 1);
        @(negedge clk);
        check("bubble ex_reg_write", 32'(bus.ex_reg_write), 0);
        check("bubble ex_mem_read", 32'(bus.ex_mem_read), 0);
        check("bubble lus", 32'(bus.load_use_stall), 0);
        @(negedge clk);
        check("after hazard ex_rd", 32'(bus.ex_rd), 7);
        check("after hazard ex_reg_write", 32'(bus.ex_reg_write), 1);

        // stall holds for three cycles while ID changes, then stall+flush bubbles
        #1 bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            @(negedge clk);
            check("stall hold ex_rd", 32'(bus.ex_rd), 7);
            #1;
        end
        bus.flush = 1;
        @(negedge clk);
        check("flush ex_rd", 32'(bus.ex_rd), 0);
        check("flush ex_reg_write", 32'(bus.ex_reg_write), 0);

        // trapping add
        #1 clear_id();
        bus.id_rd_addr = 8; bus.id_reg_write = 1; bus.id_trap_ovf = 1; bus.alu_overflow = 1;
        @(negedge clk);
        check("trap ovf ex_reg_write", 32'(bus.ex_reg_write), 0);
        #1 bus.alu_overflow = 0;
        #1 check("trap noovf ex_reg_write", 32'(bus.ex_reg_write), 1);

        // reset during stall
        bus.stall = 1; reset = 1;
        @(negedge clk);
        check("rst in stall ex_rd", 32'(bus.ex_rd), 0);
        #1 reset = 0; bus.stall = 0;

        for (int n = 0; n < 400; n++) begin
            randomize_id();
            bus.stall           = ($urandom_range(0, 99) < 15);
            bus.flush           = ($urandom_range(0, 99) < 8);
            reset               = ($urandom_range(0, 99) < 2);
            bus.exmem_reg_write = 1'($urandom); bus.exmem_rd = 5'($urandom_range(0, 3));
            bus.exmem_result    = $urandom;
            bus.memwb_reg_write = 1'($urandom); bus.memwb_rd = 5'($urandom_range(0, 3));
            bus.memwb_result    = $urandom;
            bus.alu_overflow    = 1'($urandom);
            @(negedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the ALU in the 5-stage pipelined MIPS core.
- Latches decoded instruction fields on each clock, supports stall and flush, and detects load-use hazards.
- Resolves EX/MEM and MEM/WB forwarding, then drives the ALU's In1, In2, ALUConf and Sign.
- Uses the ALU's overflow flag to suppress register writeback for trapping add/sub.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold all stage registers.
- flush  in  1  load a bubble (branch/jump squash).
- id_rs_data, id_rt_data  in  DW  register-file read data.
- id_imm32  in  DW  extended immediate.
- id_shamt  in  5  shift amount field.
- id_rs_addr, id_rt_addr, id_rd_addr  in  AW  source and destination register numbers.
- id_alu_conf  in  5  ALU operation code.
- id_sign  in  1  signed compare select.
- id_src1_shamt  in  1  In1 = shamt.
- id_src2_imm  in  1  In2 = immediate.
- id_reg_write, id_mem_read, id_mem_write, id_trap_ovf  in  1  decoded control bits.
- exmem_reg_write  in  1  EX/MEM write enable.
- exmem_rd  in  AW  EX/MEM destination.
- exmem_result  in  DW  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB write enable.
- memwb_rd  in  AW  MEM/WB destination.
- memwb_result  in  DW  MEM/WB result.
- alu_overflow  in  1  ALU overflow flag, same cycle.
- alu_in1, alu_in2  out  DW  ALU operands.
- alu_conf  out  5  ALU operation code.
- alu_sign  out  1  signed compare select.
- ex_store_data  out  DW  forwarded rt value for stores.
- ex_rd  out  AW  registered destination.
- ex_reg_write  out  1  effective write enable.
- ex_mem_read, ex_mem_write  out  1  registered memory controls.
- load_use_stall  out  1  hazard request to PC and IF/ID.

Behaviour:
- Registered state: rs/rt data, imm32, shamt, rs/rt/rd addr, alu_conf, sign, src selects, reg_write, mem_read, mem_write, trap_ovf.
- Update at posedge clk, priority reset > flush > load_use_stall > stall > load:
  - reset: every registered field = 0, i.e. a bubble. alu_conf = 0 (add), no writes, ex_rd = 0. All outputs are therefore 0 at reset, given a zero or unforwarded register-file input.
  - flush, or load_use_stall: load a bubble (all fields 0). flush wins over stall when both are asserted.
  - stall (without flush or hazard): hold all fields.
  - otherwise: load id_* inputs. Latency is 1 cycle from ID inputs to outputs.
- load_use_stall (combinational) = ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs_addr | ex_rd == id_rt_addr).
  - It is asserted for exactly one cycle per hazard, because the bubble it inserts clears ex_mem_read.
  - Upstream stages hold while it is high.
- Forwarding is combinational on the registered addresses. fwd_rs and fwd_rt are each resolved with this priority:
  1. If exmem_reg_write & exmem_rd != 0 & exmem_rd == addr: use exmem_result.
  2. Else if memwb_reg_write & memwb_rd != 0 & memwb_rd == addr: use memwb_result.
  3. Else: use the registered data.
  - Register 0 is never forwarded.
- Operand selection:
  - alu_in1 = src1_shamt ? {27'b0, shamt} : fwd_rs. The ALU shifts by In1[4:0], so variable shifts pass rs.
  - alu_in2 = src2_imm ? imm32 : fwd_rt.
  - ex_store_data = fwd_rt, always, regardless of src2_imm.
- ex_reg_write = reg_write & ~(trap_ovf & alu_overflow). Overflow only suppresses the write; there is no exception vector in this block.
- Stall while forwarding sources change: outputs follow the new forwarded values, because selection is combinational.
- reset asserted mid-stall: reset wins. A bubble is present on the next edge.

Test Plan:
- Reset → all registered fields 0, alu_conf=0, ex_reg_write=0, ex_rd=0, load_use_stall=0; alu_in1/alu_in2=0 with exmem_reg_write=0 and memwb_reg_write=0.
- Load add $3,$1,$2 with rs_data=5, rt_data=7, exmem_rd=1, exmem_result=100, memwb_rd=1, memwb_result=50 → alu_in1=100 (EX/MEM priority), alu_in2=7. Repeat with exmem_rd=0 and memwb_rd=0 → no forwarding.
- Load sll $4,$2,3 with src1_shamt=1, rt_data=0x10 → alu_in1=3, alu_in2=0x10, alu_conf=5'b11001.
- Load lw $5 into EX; in ID, an instruction with rs=5 → load_use_stall=1 for one cycle, next edge loads a bubble (ex_reg_write=0), load_use_stall=0 after.
- stall=1 for 3 cycles while id_* change → outputs unchanged. stall=1 with flush=1 → bubble.
- add with trap_ovf=1, reg_write=1, alu_overflow=1 → ex_reg_write=0. With alu_overflow=0 → ex_reg_write=1.
